// File: rtl/pong_pkg.sv
// ============================================================================
// pong_pkg : playfield and paddle geometry, position width, ball state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package pong_pkg;

    localparam int POSITION_REG_MAX = 11;
    localparam int POSITION_WIDTH   = POSITION_REG_MAX + 1;

    localparam int FIELD_X_MIN   = 50;
    localparam int FIELD_X_MAX   = 1230;
    localparam int FIELD_Y_MIN   = 50;
    localparam int FIELD_Y_MAX   = 750;

    localparam int PADDLE_WIDTH  = 20;
    localparam int PADDLE_LENGTH = 200;

    typedef enum logic [0:0] {
        SERVE_WAIT = 1'b0,
        MOVING     = 1'b1
    } ball_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_tick.sv
// ============================================================================
// frame_tick : one-cycle frame tick on the falling edge of vertical sync
// Revision   : 1.0
// ============================================================================
`default_nettype none

module frame_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic tick
);

    logic [1:0] vsync_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_hist <= 2'b00;
        end else begin
            vsync_hist <= {vsync_hist[0], vsync};
        end
    end

    assign tick = vsync_hist[1] & ~vsync_hist[0];

endmodule

`default_nettype wire

// File: rtl/ball_motion.sv
// ============================================================================
// ball_motion : per-frame ball movement, wall/paddle bounces, miss count, serve
// Optional    : BALL_MOTION_MANUAL_SERVE_EN (launch waits for serve on a tick)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ball_motion
    import pong_pkg::*;
#(
    parameter int BALL_RADIUS        = 10,
    parameter int BALL_START_X       = 640,
    parameter int BALL_START_Y       = 400,
    parameter int BALL_SPEED_X       = 4,
    parameter int BALL_SPEED_Y       = 3,
    parameter int SERVE_DELAY_FRAMES = 60
) (
    input  logic                      pixel_clock,
    input  logic                      reset_n,
    input  logic                      vertical_sync,
    input  logic [POSITION_REG_MAX:0] paddle_x,
    input  logic [POSITION_REG_MAX:0] paddle_y,
    input  logic                      serve,
    output logic [POSITION_REG_MAX:0] ball_x,
    output logic [POSITION_REG_MAX:0] ball_y,
    output logic                      ball_active,
    output logic                      miss_pulse,
    output logic [7:0]                miss_count
);

    localparam int PW = POSITION_REG_MAX + 1;
    // One extra bit keeps every sum (position + constant) free of wrap-around.
    localparam int EW = POSITION_REG_MAX + 2;
    localparam int CW = (SERVE_DELAY_FRAMES > 1) ? $clog2(SERVE_DELAY_FRAMES) : 1;

    localparam logic [CW-1:0] DELAY_LAST    = CW'(SERVE_DELAY_FRAMES - 1);
    localparam logic [EW-1:0] SPEED_X       = EW'(BALL_SPEED_X);
    localparam logic [EW-1:0] SPEED_Y       = EW'(BALL_SPEED_Y);
    localparam logic [EW-1:0] RADIUS        = EW'(BALL_RADIUS);
    localparam logic [EW-1:0] Y_TOP_LIMIT   = EW'(FIELD_Y_MIN + BALL_RADIUS);
    localparam logic [EW-1:0] Y_BOT_WALL    = EW'(FIELD_Y_MAX);
    localparam logic [EW-1:0] X_RIGHT_WALL  = EW'(FIELD_X_MAX);
    localparam logic [EW-1:0] X_LEFT_LIMIT  = EW'(FIELD_X_MIN + BALL_RADIUS);
    localparam logic [EW-1:0] FACE_OFFSET   = EW'(PADDLE_WIDTH + BALL_RADIUS);
    localparam logic [EW-1:0] PADDLE_SPAN   = EW'(PADDLE_LENGTH + BALL_RADIUS);
    localparam logic [PW-1:0] START_X       = PW'(BALL_START_X);
    localparam logic [PW-1:0] START_Y       = PW'(BALL_START_Y);
    localparam logic [PW-1:0] Y_TOP_CLAMP   = PW'(FIELD_Y_MIN + BALL_RADIUS);
    localparam logic [PW-1:0] Y_BOT_CLAMP   = PW'(FIELD_Y_MAX - BALL_RADIUS);
    localparam logic [PW-1:0] X_RIGHT_CLAMP = PW'(FIELD_X_MAX - BALL_RADIUS);

    ball_state_t   state, state_next;
    logic          dir_x, dir_y, dir_x_next, dir_y_next;   // 1 = increasing
    logic [CW-1:0] delay_cnt, cnt_next;
    logic [PW-1:0] x_next, y_next;
    logic          pulse_next;
    logic [7:0]    count_next;

    logic          tick;
    logic          launch_ok;
    logic [EW-1:0] cur_x, cur_y, nx, ny, face_x, pad_top, pad_bot;
    logic          hit_top, hit_bottom, hit_right, hit_paddle, missed;

    frame_tick u_frame_tick (
        .clk   (pixel_clock),
        .rst_n (reset_n),
        .vsync (vertical_sync),
        .tick  (tick)
    );

`ifdef BALL_MOTION_MANUAL_SERVE_EN
    assign launch_ok = serve;
`else
    // Automatic launch: serve is read but cannot hold the ball back.
    assign launch_ok = serve | 1'b1;
`endif

    always_comb begin
        cur_x      = {1'b0, ball_x};
        cur_y      = {1'b0, ball_y};
        nx         = dir_x ? (cur_x + SPEED_X) : (cur_x - SPEED_X);
        ny         = dir_y ? (cur_y + SPEED_Y) : (cur_y - SPEED_Y);
        face_x     = {1'b0, paddle_x} + FACE_OFFSET;
        pad_top    = {1'b0, paddle_y};
        pad_bot    = pad_top + PADDLE_SPAN;
        hit_top    = !dir_y && (ny <= Y_TOP_LIMIT);
        hit_bottom = dir_y && ((ny + RADIUS) >= Y_BOT_WALL);
        hit_right  = dir_x && ((nx + RADIUS) >= X_RIGHT_WALL);
        hit_paddle = !dir_x && (cur_x >= face_x) && (nx <= face_x)
                     && ((cur_y + RADIUS) >= pad_top) && (cur_y <= pad_bot);
        missed     = !dir_x && !hit_paddle && (nx <= X_LEFT_LIMIT);
    end

    always_comb begin
        state_next = state;
        x_next     = ball_x;
        y_next     = ball_y;
        dir_x_next = dir_x;
        dir_y_next = dir_y;
        cnt_next   = delay_cnt;
        pulse_next = 1'b0;
        count_next = miss_count;
        if (tick) begin
            case (state)
                SERVE_WAIT: begin
                    if (delay_cnt != DELAY_LAST) begin
                        cnt_next = delay_cnt + CW'(1);
                    end else if (launch_ok) begin
                        state_next = MOVING;
                        cnt_next   = '0;
                        dir_x_next = 1'b1;
                        dir_y_next = ~dir_y;
                    end
                end
                MOVING: begin
                    x_next = nx[PW-1:0];
                    y_next = ny[PW-1:0];
                    if (hit_top) begin
                        y_next     = Y_TOP_CLAMP;
                        dir_y_next = 1'b1;
                    end else if (hit_bottom) begin
                        y_next     = Y_BOT_CLAMP;
                        dir_y_next = 1'b0;
                    end
                    if (hit_right) begin
                        x_next     = X_RIGHT_CLAMP;
                        dir_x_next = 1'b0;
                    end else if (hit_paddle) begin
                        x_next     = face_x[PW-1:0];
                        dir_x_next = 1'b1;
                    end else if (missed) begin
                        // A miss discards any Y bounce computed this tick.
                        state_next = SERVE_WAIT;
                        x_next     = START_X;
                        y_next     = START_Y;
                        dir_y_next = dir_y;
                        pulse_next = 1'b1;
                        count_next = (miss_count == 8'hFF) ? miss_count : miss_count + 8'd1;
                    end
                end
                default: state_next = SERVE_WAIT;
            endcase
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SERVE_WAIT;
            ball_x     <= START_X;
            ball_y     <= START_Y;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            delay_cnt  <= '0;
            miss_pulse <= 1'b0;
            miss_count <= 8'd0;
        end else begin
            state      <= state_next;
            ball_x     <= x_next;
            ball_y     <= y_next;
            dir_x      <= dir_x_next;
            dir_y      <= dir_y_next;
            delay_cnt  <= cnt_next;
            miss_pulse <= pulse_next;
            miss_count <= count_next;
        end
    end

    assign ball_active = (state == MOVING);

endmodule

`default_nettype wire

// File: tb/tb_ball_motion.sv
// ============================================================================
// tb_ball_motion : scoreboard bench for ball_motion plus a miss-saturation unit
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_ball_motion;

    logic        clk = 1'b0;
    logic        reset_n, rst2_n, vsync, serve;
    logic [11:0] paddle_x, paddle_y;
    logic [11:0] ball_x, ball_y, b2_x, b2_y;
    logic        ball_active, miss_pulse, b2_active, b2_pulse;
    logic [7:0]  miss_count, b2_count;

    always #5 clk = ~clk;

    ball_motion dut (
        .pixel_clock   (clk),
        .reset_n       (reset_n),
        .vertical_sync (vsync),
        .paddle_x      (paddle_x),
        .paddle_y      (paddle_y),
        .serve         (serve),
        .ball_x        (ball_x),
        .ball_y        (ball_y),
        .ball_active   (ball_active),
        .miss_pulse    (miss_pulse),
        .miss_count    (miss_count)
    );

    // Fast-missing instance: starts near the right wall, moves 56 px per frame.
    ball_motion #(
        .BALL_START_X       (1200),
        .BALL_SPEED_X       (56),
        .SERVE_DELAY_FRAMES (1)
    ) dut_sat (
        .pixel_clock   (clk),
        .reset_n       (rst2_n),
        .vertical_sync (vsync),
        .paddle_x      (12'd0),
        .paddle_y      (12'd0),
        .serve         (1'b1),
        .ball_x        (b2_x),
        .ball_y        (b2_y),
        .ball_active   (b2_active),
        .miss_pulse    (b2_pulse),
        .miss_count    (b2_count)
    );

    typedef struct {
        int tick;
        int x;
        int y;
        int act;
        int pulse;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t anchors[$];
    exp_t mon_e;
    int   compared = 0;
    int   mismatched = 0;
    bit   checking = 1'b0;
    int   phase = 0;
    int   n2 = 0;

    // Reference ball, kept in signed integers with +1/-1 directions.
    int mx, my, mdx, mdy, mcnt, mstate, mpulse, mcount;

    task automatic chk(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        mx = 640; my = 400; mdx = 1; mdy = 1;
        mcnt = 0; mstate = 0; mpulse = 0; mcount = 0;
    endtask

    task automatic model_tick(input int px, input int py, input int srv);
        int nx, ny, ey, edy, face;
        bit hit;
        mpulse = 0;
        if (mstate == 0) begin
            if (mcnt == 59) begin
`ifdef BALL_MOTION_MANUAL_SERVE_EN
                if (srv != 0) begin
`else
                if (srv >= 0) begin
`endif
                    mstate = 1; mcnt = 0; mdx = 1; mdy = -mdy;
                end
            end else begin
                mcnt++;
            end
        end else begin
            nx = mx + 4 * mdx;
            ny = my + 3 * mdy;
            ey = ny; edy = mdy;
            if (mdy < 0 && ny <= 60) begin ey = 60; edy = 1; end
            else if (mdy > 0 && ny >= 740) begin ey = 740; edy = -1; end
            face = px + 30;
            hit = (mdx < 0) && (mx >= face) && (nx <= face) && (my + 10 >= py) && (my <= py + 210);
            if (mdx > 0 && nx >= 1220) begin
                mx = 1220; mdx = -1; my = ey; mdy = edy;
            end else if (hit) begin
                mx = face; mdx = 1; my = ey; mdy = edy;
            end else if (mdx < 0 && nx <= 60) begin
                mx = 640; my = 400; mstate = 0; mpulse = 1;
                mcount = (mcount >= 255) ? 255 : mcount + 1;
            end else begin
                mx = nx; my = ey; mdy = edy;
            end
        end
    endtask

    task automatic issue(input int t);
        int px;
        px = (phase == 1 && t > 476) ? 0 : 110;
        paddle_x = 12'(px);
        paddle_y = 12'd400;
        serve    = (t > 100);
        model_tick(px, 400, (t > 100) ? 1 : 0);
        sb.push_back('{t, mx, my, mstate, mpulse, mcount});
    endtask

    // Drops reset between clock edges, checks the asynchronous return, then
    // re-arms the scoreboard so the next vsync fall is tick 1.
    task automatic do_reset();
        @(posedge vsync);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_x", int'(ball_x), 640);
        chk("rst_y", int'(ball_y), 400);
        chk("rst_active", int'(ball_active), 0);
        chk("rst_pulse", int'(miss_pulse), 0);
        chk("rst_count", int'(miss_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        issue(1);
        checking = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        checking = 1'b0;
    endtask

    initial begin
        vsync = 1'b1;
        forever begin
            repeat (2) @(negedge clk);
            vsync = 1'b0;
            repeat (2) @(negedge clk);
            vsync = 1'b1;
        end
    end

    // Monitor: each vsync fall yields new outputs two clock edges later.
    initial begin
        forever begin
            @(negedge vsync);
            if (checking) begin
                repeat (2) @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_underflow: DUT updated with no expected entry");
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("x@%0d", mon_e.tick), int'(ball_x), mon_e.x);
                    chk($sformatf("y@%0d", mon_e.tick), int'(ball_y), mon_e.y);
                    chk($sformatf("active@%0d", mon_e.tick), int'(ball_active), mon_e.act);
                    chk($sformatf("pulse@%0d", mon_e.tick), int'(miss_pulse), mon_e.pulse);
                    chk($sformatf("count@%0d", mon_e.tick), int'(miss_count), mon_e.cnt);
                    foreach (anchors[i]) begin
                        if (anchors[i].tick == mon_e.tick) begin
                            chk($sformatf("anchor_x@%0d", mon_e.tick), int'(ball_x), anchors[i].x);
                            chk($sformatf("anchor_y@%0d", mon_e.tick), int'(ball_y), anchors[i].y);
                            chk($sformatf("anchor_act@%0d", mon_e.tick), int'(ball_active), anchors[i].act);
                            chk($sformatf("anchor_pulse@%0d", mon_e.tick), int'(miss_pulse), anchors[i].pulse);
                            chk($sformatf("anchor_cnt@%0d", mon_e.tick), int'(miss_count), anchors[i].cnt);
                        end
                    end
                    if (mon_e.pulse != 0) begin
                        @(posedge clk);
                        #1;
                        chk($sformatf("pulse_width@%0d", mon_e.tick), int'(miss_pulse), 0);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst2_n && b2_pulse) begin
                n2++;
                chk($sformatf("sat_count@%0d", n2), int'(b2_count), (n2 > 255) ? 255 : n2);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifndef BALL_MOTION_MANUAL_SERVE_EN
        anchors.push_back('{59,   640,  400, 0, 0, 0});
        anchors.push_back('{60,   640,  400, 1, 0, 0});
        anchors.push_back('{62,   648,  394, 1, 0, 0});
        anchors.push_back('{174,  1096, 60,  1, 0, 0});
        anchors.push_back('{175,  1100, 63,  1, 0, 0});
        anchors.push_back('{205,  1220, 153, 1, 0, 0});
        anchors.push_back('{401,  436,  740, 1, 0, 0});
        anchors.push_back('{475,  140,  518, 1, 0, 0});
        anchors.push_back('{476,  144,  515, 1, 0, 0});
        anchors.push_back('{1035, 640,  400, 0, 1, 1});
`endif
        reset_n  = 1'b1;
        rst2_n   = 1'b1;
        paddle_x = 12'd110;
        paddle_y = 12'd400;
        serve    = 1'b0;
        #2;
        reset_n = 1'b0;
        rst2_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst2_n = 1'b1;

        phase = 1;
        do_reset();
        for (int t = 2; t <= 1115; t++) begin
            @(posedge vsync);
            issue(t);
        end
        drain();

        phase = 2;
        do_reset();
        for (int t = 2; t <= 110; t++) begin
            @(posedge vsync);
            issue(t);
        end
        drain();

        for (int i = 0; i < 40000 && n2 < 258; i++) @(posedge clk);
        if (n2 < 258) begin
            compared++;
            mismatched++;
            $display("FAIL sat_misses: got %0d misses expected at least 258", n2);
        end
        chk("sat_final", int'(b2_count), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
